// File: rtl/icache_dm_ro.sv
// Direct-mapped read-only instruction cache with a two-state refill controller.
// Optional hit/miss counters are enabled by defining ICACHE_PERF_CNT_EN.
module icache_dm_ro #(
    parameter int INDEX_BITS = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic         proc_stall,
    output logic [31:0]  proc_rdata,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready,
`ifdef ICACHE_PERF_CNT_EN
    output logic [31:0]  hit_cnt,
    output logic [31:0]  miss_cnt,
`endif
    output logic         state_dbg
);

    // Memory handshake: mem_read is held with a stable mem_addr until the
    // single-cycle mem_ready pulse; mem_rdata is only sampled in that cycle.

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 28 - INDEX_BITS;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ALLOC = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [LINES-1:0]    valid;
    logic [TAG_BITS-1:0] tag_store  [LINES];
    logic [127:0]        data_store [LINES];
    logic [27:0]         miss_addr;

    logic [1:0]            offset;
    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   tag;
    logic [INDEX_BITS-1:0] fill_index;
    logic [127:0]          line_data;
    logic                  hit;
    logic                  miss_start;
    logic                  fill;
    logic                  unused_inputs;

    assign offset     = proc_addr[1:0];
    assign index      = proc_addr[INDEX_BITS+1:2];
    assign tag        = proc_addr[29:INDEX_BITS+2];
    assign fill_index = miss_addr[INDEX_BITS-1:0];

    assign hit       = proc_read & valid[index] & (tag_store[index] == tag);
    assign line_data = data_store[index];

    // Zero rather than stale data whenever there is no hit, so the port is never X.
    assign proc_rdata = hit ? line_data[{offset, 5'b00000} +: 32] : 32'b0;

    assign mem_write     = 1'b0;
    assign mem_addr      = miss_addr;
    assign state_dbg     = state;
    assign unused_inputs = ^{proc_write, proc_wdata};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        mem_read   = 1'b0;
        proc_stall = 1'b0;
        miss_start = 1'b0;
        fill       = 1'b0;
        case (state)
            S_IDLE: begin
                if (proc_read && !hit) begin
                    proc_stall = 1'b1;
                    miss_start = 1'b1;
                    state_nxt  = S_ALLOC;
                end
            end
            S_ALLOC: begin
                mem_read   = 1'b1;
                proc_stall = 1'b1;
                if (mem_ready) begin
                    fill      = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_addr <= 28'b0;
            valid     <= '0;
        end else begin
            if (miss_start) begin
                miss_addr <= proc_addr[29:2];
            end
            if (fill) begin
                valid[fill_index] <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset; valid alone qualifies their contents.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_store[fill_index]  <= miss_addr[27:INDEX_BITS];
            data_store[fill_index] <= mem_rdata;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= 32'b0;
            miss_cnt <= 32'b0;
        end else begin
            if (state == S_IDLE && hit) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (miss_start) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_dm_ro.sv
// Self-checking bench for icache_dm_ro: memory responder, expected-word queue,
// cache residency model; counter checks compile in with ICACHE_PERF_CNT_EN.
module tb_icache_dm_ro;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         proc_read = 1'b0;
    logic         proc_write = 1'b0;
    logic [29:0]  proc_addr = 30'b0;
    logic [31:0]  proc_wdata = 32'b0;
    logic         proc_stall;
    logic [31:0]  proc_rdata;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_rdata = 128'b0;
    logic         mem_ready = 1'b0;
    logic         state_dbg;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;
`endif

    int checks = 0;
    int failures = 0;
    int exp_hits = 0;
    int exp_misses = 0;
    logic [31:0] exp_q[$];

    logic        m_valid [8];
    logic [24:0] m_tag   [8];

    icache_dm_ro #(.INDEX_BITS(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_stall (proc_stall),
        .proc_rdata (proc_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
`ifdef ICACHE_PERF_CNT_EN
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt),
`endif
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [27:0] blk, input logic [1:0] w);
        logic [31:0] base;
        base = 32'h11111111 * {30'b0, w};
        return base ^ {blk[15:0], 16'h0000};
    endfunction

    function automatic logic [127:0] mem_block(input logic [27:0] blk);
        return {mem_word(blk, 2'd3), mem_word(blk, 2'd2), mem_word(blk, 2'd1), mem_word(blk, 2'd0)};
    endfunction

    function automatic bit model_miss(input logic [29:0] addr);
        return !(m_valid[addr[4:2]] && m_tag[addr[4:2]] == addr[29:5]);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    // One fetch: drive the request, play memory with the given latency, compare when stall drops.
    task automatic fetch(input logic [29:0] addr, input int lat, input bit exp_miss, input string name);
        logic [27:0] blk;
        logic [31:0] exp_w;
        int stalled;
        int alloc;
        bit done;
        blk = addr[29:2];
        stalled = 0;
        alloc = 0;
        done = 0;
        @(negedge clk);
        mem_ready  = 1'b0;
        proc_read  = 1'b1;
        proc_addr  = addr;
        proc_write = 1'($urandom_range(0, 1));
        proc_wdata = $urandom();
        exp_q.push_back(mem_word(blk, addr[1:0]));
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            if (cyc != 0) begin
                @(negedge clk);
                mem_ready = 1'b0;
                mem_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            #1;
            if (!proc_stall) begin
                done = 1;
                exp_w = exp_q.pop_front();
                checks++;
                if (proc_rdata !== exp_w)
                    $display("FAIL %s rdata: got %h expected %h", name, proc_rdata, exp_w);
                if (proc_rdata !== exp_w) failures++;
                checks++;
                if (stalled != (exp_miss ? lat + 2 : 0)) begin
                    failures++;
                    $display("FAIL %s stall_cycles: got %0d expected %0d", name, stalled, exp_miss ? lat + 2 : 0);
                end
                checks++;
                if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
                    failures++;
                    $display("FAIL %s mem_idle: got read=%b write=%b expected 0 0", name, mem_read, mem_write);
                end
            end else begin
                stalled++;
                if (mem_read) begin
                    alloc++;
                    checks++;
                    if (mem_addr !== blk) begin
                        failures++;
                        $display("FAIL %s mem_addr: got %h expected %h", name, mem_addr, blk);
                    end
                    if (alloc == lat + 1) begin
                        mem_ready = 1'b1;
                        mem_rdata = mem_block(blk);
                    end
                end
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s timeout: stall still %b after 60 cycles, expected 0", name, proc_stall);
            void'(exp_q.pop_front());
        end
        if (exp_miss) begin
            exp_misses++;
            m_valid[addr[4:2]] = 1'b1;
            m_tag[addr[4:2]]   = addr[29:5];
        end
        exp_hits++;
    endtask

    task automatic check_counters(input string name);
`ifdef ICACHE_PERF_CNT_EN
        checks++;
        if (hit_cnt !== 32'(exp_hits)) begin
            failures++;
            $display("FAIL %s hit_cnt: got %0d expected %0d", name, hit_cnt, exp_hits);
        end
        checks++;
        if (miss_cnt !== 32'(exp_misses)) begin
            failures++;
            $display("FAIL %s miss_cnt: got %0d expected %0d", name, miss_cnt, exp_misses);
        end
`else
        if (name.len() == 0) $display("counter check skipped");
`endif
    endtask

    task automatic test_reset();
        clear_model();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (proc_stall !== 1'b0 || mem_read !== 1'b0 || proc_rdata !== 32'b0 || state_dbg !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got stall=%b mem_read=%b rdata=%h state=%b expected 0 0 0 0",
                     proc_stall, mem_read, proc_rdata, state_dbg);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (proc_stall !== 1'b0 || mem_read !== 1'b0 || mem_addr !== 28'b0) begin
            failures++;
            $display("FAIL after_reset: got stall=%b mem_read=%b mem_addr=%h expected 0 0 0",
                     proc_stall, mem_read, mem_addr);
        end
        check_counters("reset");
    endtask

    task automatic test_first_miss();
        fetch(30'h0, 3, 1'b1, "first_miss");
    endtask

    task automatic test_back_to_back();
        fetch(30'h1, 0, 1'b0, "hit_w1");
        fetch(30'h2, 0, 1'b0, "hit_w2");
        fetch(30'h3, 0, 1'b0, "hit_w3");
        check_counters("after_fill");
    endtask

    task automatic test_conflict();
        fetch(30'h20, 2, 1'b1, "conflict_in");
        fetch(30'h23, 0, 1'b0, "conflict_hit");
        fetch(30'h0, 1, 1'b1, "conflict_back");
        check_counters("after_conflict");
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            proc_read  = 1'b0;
            proc_addr  = 30'($urandom());
            proc_write = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (proc_stall !== 1'b0 || mem_read !== 1'b0 || proc_rdata !== 32'b0) begin
                failures++;
                $display("FAIL idle_%0d: got stall=%b mem_read=%b rdata=%h expected 0 0 0",
                         i, proc_stall, mem_read, proc_rdata);
            end
        end
        @(negedge clk);
        check_counters("after_idle");
    endtask

    task automatic test_random();
        logic [29:0] a;
        for (int i = 0; i < 16; i++) begin
            a = 30'($urandom_range(0, 95));
            fetch(a, $urandom_range(0, 4), model_miss(a), "random");
        end
        check_counters("after_random");
    endtask

    task automatic test_reset_during_alloc();
        @(negedge clk);
        proc_read = 1'b1;
        proc_addr = 30'h40;
        @(negedge clk);
        #1;
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== 28'h10) begin
            failures++;
            $display("FAIL enter_alloc: got mem_read=%b mem_addr=%h expected 1 10", mem_read, mem_addr);
        end
        rst_n = 1'b0;
        #1;
        proc_read = 1'b0;
        checks++;
        if (mem_read !== 1'b0 || state_dbg !== 1'b0 || mem_addr !== 28'b0) begin
            failures++;
            $display("FAIL abort_alloc: got mem_read=%b state=%b mem_addr=%h expected 0 0 0",
                     mem_read, state_dbg, mem_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_model();
        mem_ready = 1'b1;
        mem_rdata = mem_block(28'h10);
        #1;
        checks++;
        if (proc_stall !== 1'b0 || mem_read !== 1'b0) begin
            failures++;
            $display("FAIL late_ready: got stall=%b mem_read=%b expected 0 0", proc_stall, mem_read);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        checks++;
        if (mem_read !== 1'b0 || state_dbg !== 1'b0) begin
            failures++;
            $display("FAIL late_ready_ignored: got mem_read=%b state=%b expected 0 0", mem_read, state_dbg);
        end
        fetch(30'h40, 2, 1'b1, "refetch_after_reset");
        check_counters("after_reset_alloc");
    endtask

    initial begin
        test_reset();
        test_first_miss();
        test_back_to_back();
        test_conflict();
        test_idle();
        test_random();
        test_reset_during_alloc();
        @(negedge clk);
        proc_read = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/icache_dm_ro.md
Name: icache_dm_ro

Overview:
- Direct-mapped, read-only instruction cache between the IF stage port (I_read/I_addr/I_rdata/I_stall) and the instruction memory.
- Hits return data combinationally with zero added latency.
- Misses assert stall and refill one 4-word block from memory through a two-state controller.
- The IF stage holds pc while stall is high, then consumes the word in the cycle stall drops.

Parameters:
- INDEX_BITS, 3, log2 of block count (default 8 blocks x 4 words x 32 bits).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- proc_read  in  1  instruction fetch request
- proc_write  in  1  ignored; read-only cache
- proc_addr  in  30  word address (byte address [31:2])
- proc_wdata  in  32  ignored
- proc_stall  out  1  high while the requested word is not yet available
- proc_rdata  out  32  instruction word, valid when proc_read=1 and proc_stall=0
- mem_read  out  1  block read request to memory
- mem_write  out  1  constant 0
- mem_addr  out  28  block address (proc_addr[29:2] of the missed access)
- mem_rdata  in  128  refill block; word 0 in [31:0], word 3 in [127:96]
- mem_ready  in  1  one-cycle pulse; mem_rdata valid in that cycle

Behaviour:
- Address split:
  - offset = proc_addr[1:0]
  - index = proc_addr[INDEX_BITS+1:2]
  - tag = proc_addr[29:INDEX_BITS+2] (28-INDEX_BITS bits)
- Storage per line: valid bit, tag, 128-bit data. Flops only, no SRAM macro.
- hit = proc_read & valid[index] & (tag_store[index]==tag). Combinational.
- FSM states:
  - S_IDLE:
    - On proc_read & ~hit: latch block address into miss_addr, go to S_ALLOC.
    - On hit, or when proc_read=0: stay in S_IDLE.
  - S_ALLOC:
    - mem_read=1; mem_addr=miss_addr, held stable until mem_ready.
    - On mem_ready: write mem_rdata into line miss_addr[INDEX_BITS-1:0], set its tag and valid, go to S_IDLE. mem_read drops the next cycle.
- proc_stall:
  - In S_IDLE: proc_read & ~hit, combinational in the same cycle as the request.
  - In S_ALLOC: 1, including the mem_ready cycle.
- Miss timing: the first cycle after returning to S_IDLE is a hit for the same proc_addr, so stall drops and data is delivered. Minimum miss penalty = memory latency + 1 cycle.
- proc_rdata: data[index] word selected by offset. Drives 32'b0 when proc_read=0 or on a miss. Never X.
- Address change during S_ALLOC: the refill completes for the latched miss_addr. The new proc_addr is re-evaluated in S_IDLE and may miss again. No request is dropped.
- proc_read deasserted during S_ALLOC: the refill still completes. proc_stall stays high until S_IDLE.
- Conflict miss (same index, different tag): the line is overwritten unconditionally. No writeback, since the cache is never dirty.
- proc_write=1: no effect on state or outputs; behaves as if only proc_read is considered.
- Reset:
  - Asynchronous clear of all valid bits, state to S_IDLE, miss_addr to 0.
  - mem_read=0, proc_stall=0 if proc_read=0.
  - Data and tag arrays need no reset.
  - Reset during S_ALLOC abandons the refill. A late mem_ready after reset is ignored in S_IDLE.

Optional Feature:
- Macro ICACHE_PERF_CNT_EN.
- When defined, adds two outputs, hit_cnt (32) and miss_cnt (32):
  - Both reset to 0 and wrap at 2^32.
  - hit_cnt increments on each cycle with state S_IDLE & proc_read & hit.
  - miss_cnt increments once per S_IDLE->S_ALLOC transition.
- Not defined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, proc_read=1, proc_addr=0:
  - proc_stall=1 immediately; next cycle mem_read=1, mem_addr=0.
  - Bench returns mem_ready after 3 cycles with mem_rdata=128'h33333333_22222222_11111111_00000000.
  - Stall drops one cycle after mem_ready; proc_rdata=32'h00000000.
  - Total stalled cycles = 5.
- After the fill, proc_addr=1,2,3 back-to-back: proc_stall=0 every cycle; proc_rdata=32'h11111111, 32'h22222222, 32'h33333333; mem_read stays 0.
- Conflict: proc_addr=30'h20 (same index 0, tag 1):
  - Miss, mem_addr=28'h8, line refilled.
  - Returning to proc_addr=0 misses again, mem_addr=0.
- proc_read=0 for 10 cycles with random proc_addr: proc_stall=0, mem_read=0, proc_rdata=0. With the macro on, counters are unchanged.
- Assert rst_n low 1 cycle into S_ALLOC, then pulse mem_ready after reset:
  - mem_read=0 after reset; line stays invalid.
  - Next read of the same address misses again.
- ICACHE_PERF_CNT_EN defined, with the first three scenarios run: hit_cnt=4 (3 after fill plus the post-refill hit), miss_cnt=1 after scenarios 1-2, miss_cnt=3 after scenario 3.
